bc_control_sequencer: RTL
=========================

BC_CONTROL_SEQUENCER -- requirements
Module: bc_control_sequencer

Interface
REQ-001 SHALL provide port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide port sc  in  4  current sequence counter value T index.
REQ-004 SHALL provide port opcode  in  3  IR[14:12].
REQ-005 SHALL provide port i_bit  in  1  IR[15], indirect flag.
REQ-006 SHALL provide port ir_low  in  12  IR[11:0], register-ref/IO micro-op bits.
REQ-007 SHALL provide port fgi, fgo  in  1 each  input/output device flags.
REQ-008 SHALL provide port inc_sc, clr_sc  out  1 each  sequence counter increment/clear commands.
REQ-009 SHALL provide port t  out  16  one-hot decode of sc.
REQ-010 SHALL provide port d  out  8  one-hot decode of opcode.
REQ-011 SHALL provide port r_flag, ien, halted, seq_err  out  1 each  interrupt-cycle flag, interrupt enable, halt state, sticky sequencing error.

Function
REQ-012 SHALL drive exactly one of inc_sc/clr_sc high in every cycle, including reset and halt; never both, never neither.
REQ-013 SHALL compute inc_sc, clr_sc, t and d combinationally from sc, opcode, ir_low, r_flag and state, with zero latency.
REQ-014 SHALL implement two states: RUN and HALT; reset enters RUN.
REQ-015 In RUN with r_flag=0: T0, T1, T2 -> inc_sc; T3 with opcode=3'b111 (register-ref or IO) -> clr_sc.
REQ-016 SHALL issue clr_sc for memory-ref instructions at the terminal step, independent of i_bit (T3 serves indirect fetch or idle): AND/ADD/LDA/BSA at T5; STA/BUN at T4; ISZ at T6; otherwise inc_sc.
REQ-017 SHALL enter HALT on the rising edge where RUN, r_flag=0, T3, opcode=3'b111, i_bit=0 and ir_low[0]=1 (HLT).
REQ-018 In HALT: clr_sc held high, r_flag/ien frozen, no exit except rst.
REQ-019 SHALL set r_flag on the rising edge where sc not in {0,1,2}, ien=1 and (fgi|fgo)=1.
REQ-020 With r_flag=1: T0, T1 -> inc_sc; at T2 -> clr_sc, and on that edge clear r_flag and ien; instruction decode suppressed (d still driven, no terminal-step clears, no HLT).
REQ-021 IO instruction (opcode=3'b111, i_bit=1) at T3: ir_low[7]=1 sets ien (ION), ir_low[6]=1 clears ien (IOF); both set -> ien unchanged.
REQ-022 SHALL set seq_err (sticky until rst) on any edge in RUN where sc exceeds the legal terminal step for the current path (r_flag=1: sc>2; otherwise sc>6); outputs continue per REQ-012 with clr_sc forced high while the error condition holds.
REQ-023 Simultaneous HLT and interrupt-set condition SHALL resolve HLT first; r_flag not set.

Reset
REQ-024 On rst=1 at rising edge: state=RUN, r_flag=0, ien=0, seq_err=0, halted=0.
REQ-025 While rst=1, clr_sc=1 and inc_sc=0 regardless of sc; reset mid-instruction or mid-interrupt-cycle abandons it.

Configuration
REQ-026 Macro INTERRUPT_EN defined: r_flag, ien, ION/IOF and REQ-019/020 behaviour present.
REQ-027 INTERRUPT_EN undefined: r_flag and ien tied 0, fgi/fgo and ir_low[7:6] ignored, all other behaviour unchanged.

Verification
REQ-028 rst 1 cycle, sc=0 -> clr_sc=1, ien=0, r_flag=0; then sc=0,1,2 -> inc_sc=1, t=16'h0001/0002/0004.
REQ-029 opcode=3'b110 (ISZ), sc stepping 0..6 -> inc_sc at T0..T5, clr_sc at T6; opcode=3'b011 (STA) -> clr_sc at T4.
REQ-030 opcode=3'b111, i_bit=0, ir_low=12'h001 at T3 -> clr_sc=1, halted=1 next cycle; later sc=0 -> clr_sc stays 1 until rst.
REQ-031 ION (ir_low=12'h080, i_bit=1) at T3, then fgi=1 at sc=4 -> r_flag=1; RT0,RT1 inc_sc, RT2 clr_sc, then r_flag=0, ien=0.
REQ-032 sc=4'd9 in RUN, r_flag=0 -> clr_sc=1, seq_err=1 next edge, retained until rst.
REQ-033 Build without INTERRUPT_EN, repeat REQ-031 stimulus -> ien=0, r_flag=0 throughout.

Source files
------------

// File: rtl/bc_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bc_control_sequencer
// Description : Timing and control sequencer for a basic-computer style CPU.
//               Decodes the sequence counter (T index) and the opcode into
//               one-hot buses. Decides on each cycle whether the external
//               sequence counter advances or clears. Tracks the RUN/HALT
//               state, the interrupt cycle flag (R), the interrupt enable
//               (IEN) and a sticky sequencing-error flag.
//
// Ports       : clk      - single clock, rising edge
//               rst      - synchronous active-high reset
//               sc       - current sequence counter value (T index)
//               opcode   - IR[14:12]
//               i_bit    - IR[15], indirect / IO flag
//               ir_low   - IR[11:0], register-ref / IO micro-op bits
//               fgi/fgo  - input / output device flags
//               inc_sc   - advance sequence counter (exactly one of inc/clr)
//               clr_sc   - clear sequence counter
//               t        - one-hot decode of sc
//               d        - one-hot decode of opcode
//               r_flag   - interrupt cycle in progress
//               ien      - interrupt enable
//               halted   - HLT executed, only rst leaves this state
//               seq_err  - sticky: sc went past the legal terminal step
//
// Config      : INTERRUPT_EN - when defined, builds the interrupt cycle,
//               IEN and the ION/IOF instructions. When undefined, r_flag and
//               ien are tied low and fgi/fgo/ir_low[7:6] are ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bc_control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sc,
    input  logic [2:0]  opcode,
    input  logic        i_bit,
    input  logic [11:0] ir_low,
    input  logic        fgi,
    input  logic        fgo,
    output logic        inc_sc,
    output logic        clr_sc,
    output logic [15:0] t,
    output logic [7:0]  d,
    output logic        r_flag,
    output logic        ien,
    output logic        halted,
    output logic        seq_err
);

    localparam logic [0:0] c_RUN  = 1'b0;
    localparam logic [0:0] c_HALT = 1'b1;

    localparam logic [2:0] c_OP_AND = 3'd0;
    localparam logic [2:0] c_OP_ADD = 3'd1;
    localparam logic [2:0] c_OP_LDA = 3'd2;
    localparam logic [2:0] c_OP_STA = 3'd3;
    localparam logic [2:0] c_OP_BUN = 3'd4;
    localparam logic [2:0] c_OP_BSA = 3'd5;
    localparam logic [2:0] c_OP_ISZ = 3'd6;
    localparam logic [2:0] c_OP_RIO = 3'd7;

    logic [0:0] r_state;
    logic       r_seq_err;

    logic       w_run;
    logic       w_rio_t3;
    logic       w_hlt;
    logic       w_err;
    logic       w_term;
    logic       w_clr;

    // ------------------------------------------------------------------------
    // Decoders
    // ------------------------------------------------------------------------
    assign t = 16'h0001 << sc;
    assign d = 8'h01 << opcode;

    assign w_run    = (r_state == c_RUN);
    assign w_rio_t3 = (sc == 4'd3) && (opcode == c_OP_RIO);

    // HLT only fires on the normal instruction path, never in an interrupt
    // cycle; it also takes precedence over a coincident interrupt request.
    assign w_hlt = w_run && !r_flag && w_rio_t3 && !i_bit && ir_low[0];

    // The interrupt cycle ends at T2, an instruction at T6 at the latest.
    assign w_err = w_run && (r_flag ? (sc > 4'd2) : (sc > 4'd6));

    // Terminal step of the normal instruction path. T3 of a memory-ref
    // instruction is indirect fetch (or idle), so i_bit does not matter.
    always_comb begin
        w_term = 1'b0;
        case (opcode)
            c_OP_AND, c_OP_ADD,
            c_OP_LDA, c_OP_BSA: w_term = (sc == 4'd5);
            c_OP_STA, c_OP_BUN: w_term = (sc == 4'd4);
            c_OP_ISZ:           w_term = (sc == 4'd6);
            c_OP_RIO:           w_term = (sc == 4'd3);
            default:            w_term = 1'b0;
        endcase
    end

    // Exactly one of inc_sc/clr_sc is high; rst acts combinationally so the
    // counter is held at zero for as long as reset is asserted.
    always_comb begin
        w_clr = 1'b0;
        if (rst) begin
            w_clr = 1'b1;
        end else if (!w_run) begin
            w_clr = 1'b1;
        end else if (w_err) begin
            w_clr = 1'b1;
        end else if (r_flag) begin
            w_clr = (sc == 4'd2);
        end else begin
            w_clr = w_term;
        end
    end

    assign clr_sc = w_clr;
    assign inc_sc = ~w_clr;

    // ------------------------------------------------------------------------
    // RUN/HALT state and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_RUN;
            r_seq_err <= 1'b0;
        end else if (w_run) begin
            if (w_hlt) begin
                r_state <= c_HALT;
            end
            if (w_err) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign halted  = (r_state == c_HALT);
    assign seq_err = r_seq_err;

    // ------------------------------------------------------------------------
    // Interrupt cycle flag and interrupt enable
    // ------------------------------------------------------------------------
`ifdef INTERRUPT_EN
    logic r_int;
    logic r_ien;
    logic w_int_req;
    logic w_io_t3;
    logic w_unused;

    assign w_io_t3   = w_rio_t3 && i_bit;
    assign w_int_req = (sc > 4'd2) && r_ien && (fgi || fgo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int <= 1'b0;
            r_ien <= 1'b0;
        end else if (w_run) begin
            if (r_int) begin
                // RT2 completes the interrupt cycle and disables interrupts.
                if (sc == 4'd2) begin
                    r_int <= 1'b0;
                    r_ien <= 1'b0;
                end
            end else begin
                if (w_io_t3) begin
                    // ION and IOF together cancel out.
                    if (ir_low[7] && !ir_low[6]) begin
                        r_ien <= 1'b1;
                    end else if (ir_low[6] && !ir_low[7]) begin
                        r_ien <= 1'b0;
                    end
                end
                if (w_int_req && !w_hlt) begin
                    r_int <= 1'b1;
                end
            end
        end
    end

    assign r_flag = r_int;
    assign ien    = r_ien;

    assign w_unused = &{1'b0, ir_low[11:8], ir_low[5:1]};
`else
    logic w_unused;

    assign r_flag = 1'b0;
    assign ien    = 1'b0;

    assign w_unused = &{1'b0, fgi, fgo, ir_low[11:1]};
`endif

endmodule
`default_nettype wire
